// File: rtl/decoder_pkg.sv
// decoder_pkg: mode encodings and FSM state type shared by the scan decoder files.
package decoder_pkg;
   localparam logic [1:0] MODE_ONEHOT = 2'b00;
   localparam logic [1:0] MODE_THERM  = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;
   typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/decode_core.sv
// decode_core: combinational code to one-hot / thermometer pattern.
//   code  : W-bit code to decode
//   therm : 1 selects thermometer (bits 0..code set), 0 selects one-hot
//   pat   : N-bit decoded pattern
module decode_core #(
   parameter  int W = 3,
   localparam int N = 2**W
) (
   input  logic [W-1:0] code,
   input  logic         therm,
   output logic [N-1:0] pat
);
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign pat[i] = therm ? (code >= W'(i)) : (code == W'(i));
   end
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot / thermometer decoder with an N-beat scan mode.
//   clk, reset (async, active-low), en (global enable)
//   in_valid/in_ready/code/mode : request side
//   out_valid/out_ready/result/out_last : registered result stream
module scan_decoder
   import decoder_pkg::*;
#(
   parameter  int W = 3,
   localparam int N = 2**W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] code,
   input  logic [1:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         out_last
);
   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d, cur_q, cur_d;
   logic [N-1:0] res_q, res_d, pat;
   logic         valid_q, valid_d, last_q, last_d;
   logic         accept, xfer, step;
   assign in_ready  = en && state_q == IDLE && (!valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign xfer      = valid_q && out_ready;
   // next scan beat loads whenever the output slot frees up (or is already empty)
   assign step      = state_q == SCAN && en && (!valid_q || out_ready);
   assign out_valid = valid_q;
   assign result    = res_q;
   assign out_last  = last_q;
   decode_core #(.W(W)) u_core (
      .code  (accept ? code : cur_q + 1'b1),
      .therm (accept && mode == MODE_THERM),
      .pat   (pat)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      res_d   = res_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (accept) begin
         res_d   = pat;
         valid_d = 1'b1;
         cur_d   = code;
         last_d  = mode != MODE_SCAN;
         state_d = mode == MODE_SCAN ? SCAN : IDLE;
         cnt_d   = mode == MODE_SCAN ? W'(1) : '0;
      end else if (step) begin
         // counter at N-1 means this load is the N-th beat; counter wraps back to 0
         res_d   = pat;
         valid_d = 1'b1;
         cur_d   = cur_q + 1'b1;
         cnt_d   = cnt_q + 1'b1;
         last_d  = &cnt_q;
         state_d = &cnt_q ? IDLE : SCAN;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cur_q   <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: self-checking bench for scan_decoder (W=3) with a beat-queue model.
module tb_scan_decoder;
   import decoder_pkg::*;
   logic       clk = 0, reset = 0, en = 1, in_valid = 0, out_ready = 1;
   logic [2:0] code = 0;
   logic [1:0] mode = 0;
   logic       in_ready, out_valid, out_last;
   logic [7:0] result;
   int         checks = 0, errors = 0;
   logic [8:0] exp_q[$], rx[$], lit[$];
   logic       m_valid = 0, m_scan = 0, e_ready, xfer;
   scan_decoder #(.W(3)) dut (
      .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .code(code), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_last(out_last)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   // Model: each accept queues the whole list of beats it must produce; the queue
   // front is what the output must show whenever a beat is expected.
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_result", result, 0);
         chk("rst_last", out_last, 0);
         exp_q.delete();
         m_valid = 0;
         m_scan  = 0;
      end else begin
         e_ready = en && !m_scan && (!m_valid || out_ready);
         chk("in_ready", in_ready, e_ready);
         chk("out_valid", out_valid, m_valid);
         if (m_valid) begin
            chk("result", result, exp_q[0][7:0]);
            chk("out_last", out_last, exp_q[0][8]);
         end
         xfer = m_valid && out_ready;
         if (xfer) begin
            rx.push_back({out_last, result});
            void'(exp_q.pop_front());
         end
         if (in_valid && e_ready) begin
            if (mode == MODE_THERM) exp_q.push_back({1'b1, 8'((2 << code) - 1)});
            else if (mode == MODE_SCAN) begin
               for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, 8'(1 << ((int'(code) + k) % 8))});
               m_scan = 1;
            end else exp_q.push_back({1'b1, 8'(1 << code)});
            m_valid = 1;
         end else if (m_scan && en && (!m_valid || out_ready)) begin
            m_valid = 1;
            if (exp_q.size() == 0 || exp_q[0][8]) m_scan = 0;
         end else if (xfer) m_valid = 0;
      end
   end
   task automatic send(input logic [1:0] m, input logic [2:0] c);
      bit done = 0;
      in_valid = 1; mode = m; code = c;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("accept_timeout", done, 1);
   endtask
   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!out_valid && in_ready) done = 1;
      end
      @(posedge clk); #1;
      chk("drain_timeout", done, 1);
   endtask
   task automatic check_rx(input string nm);
      chk({nm, "_count"}, rx.size(), lit.size());
      for (int i = 0; i < lit.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), (i < rx.size()) ? 32'(rx[i]) : 32'hdead, 32'(lit[i]));
      rx.delete();
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1;
      chk("ready_after_reset", in_ready, 1);
      @(posedge clk); #1;
      rx.delete();
      for (int c = 0; c < 8; c++) send(MODE_ONEHOT, 3'(c));
      drain();
      lit = '{9'h101, 9'h102, 9'h104, 9'h108, 9'h110, 9'h120, 9'h140, 9'h180};
      check_rx("onehot");
      send(MODE_THERM, 0); send(MODE_THERM, 3); send(MODE_THERM, 7);
      drain();
      lit = '{9'h101, 9'h10F, 9'h1FF};
      check_rx("therm");
      send(MODE_SCAN, 6);
      send(2'b11, 5);
      drain();
      lit = '{9'h040, 9'h080, 9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h120, 9'h120};
      check_rx("scan6_then_held");
      send(MODE_SCAN, 0);
      repeat (2) @(posedge clk);
      #1 out_ready = 0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1;
      drain();
      lit = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h180};
      check_rx("scan_stall");
      send(MODE_SCAN, 3);
      repeat (2) @(posedge clk);
      #1 en = 0;
      repeat (2) @(posedge clk);
      #1 en = 1;
      drain();
      lit = '{9'h008, 9'h010, 9'h020, 9'h040, 9'h080, 9'h001, 9'h002, 9'h104};
      check_rx("scan_en_gap");
      send(MODE_SCAN, 0);
      repeat (3) @(posedge clk);
      #2 reset = 0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_result", result, 0);
      chk("async_rst_last", out_last, 0);
      @(posedge clk); #1 reset = 1;
      chk("ready_after_release", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 chk("no_beat_after_release", out_valid, 0);
      rx.delete();
      send(MODE_ONEHOT, 2);
      drain();
      lit = '{9'h104};
      check_rx("after_reset");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 The block SHALL have parameter W, default 3, meaning code width; legal range 1..6.
REQ-002 The block SHALL derive the constant N = 2**W, meaning output width; it is not overridable.
REQ-003 Port clk SHALL be input, 1 bit: the single clock, rising edge.
REQ-004 Port reset SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-005 Port en SHALL be input, 1 bit: global enable; 0 freezes acceptance and scan stepping.
REQ-006 Port in_valid SHALL be input, 1 bit: request present.
REQ-007 Port in_ready SHALL be output, 1 bit: request can be accepted this cycle.
REQ-008 Port code SHALL be input, W bits: code to decode; start code in scan mode.
REQ-009 Port mode SHALL be input, 2 bits: 00 one-hot, 01 thermometer, 10 scan, 11 reserved (behaves as one-hot).
REQ-010 Port out_valid SHALL be output, 1 bit: result holds a beat.
REQ-011 Port out_ready SHALL be input, 1 bit: consumer takes the beat.
REQ-012 Port result SHALL be output, N bits: decoded pattern, registered.
REQ-013 Port out_last SHALL be output, 1 bit: beat is a single decode or the final scan beat.

Function
REQ-014 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-015 in_ready SHALL be combinational: en AND state==IDLE AND (NOT out_valid OR out_ready).
REQ-016 Latency SHALL be 1 cycle from accept to out_valid=1 with the corresponding result.
REQ-017 One-hot: result SHALL have only bit[code] set.
REQ-018 Thermometer: result bit i SHALL be 1 for i <= code and 0 otherwise (code 0 gives 0..01; code N-1 gives all ones).
REQ-019 A one-hot or thermometer accept SHALL set out_last=1 and leave the state at IDLE.
REQ-020 Transfer SHALL occur when out_valid and out_ready are both 1; without a new load, out_valid SHALL drop the next cycle.
REQ-021 While out_valid=1 and out_ready=0, result, out_last and out_valid SHALL hold stable.
REQ-022 States SHALL be IDLE and SCAN.
REQ-023 A scan accept SHALL load one-hot(code), set the step counter to 1 and out_last=0, and enter SCAN.
REQ-024 In SCAN, each transfer with en=1 SHALL load one-hot(previous code + 1 mod N) in the same edge, with no bubble, and increment the counter.
REQ-025 The load at which the counter reaches N-1 SHALL set out_last=1 and return the state to IDLE; a scan emits exactly N beats covering every code once.
REQ-026 Code increment SHALL wrap from N-1 to 0: start 6 with W=3 emits 6,7,0,1,...,5.
REQ-027 In SCAN, in_ready SHALL be 0; an in_valid presented there is not accepted and must be held by the source.
REQ-028 en=0 in SCAN SHALL suppress the next-beat load; a pending beat may still transfer (out_valid then falls); stepping resumes at the next transfer opportunity after en=1.
REQ-029 When W=1, scan mode SHALL emit 2 beats, the second with out_last=1.

Reset
REQ-030 Reset assertion SHALL act immediately, including mid-scan, forcing out_valid=0, result=0, out_last=0, counter=0, state=IDLE.
REQ-031 After reset deassertion with en=1, in_ready SHALL be 1; no beat is emitted until an accept occurs.

Structure
REQ-032 Package decoder_pkg SHALL hold the mode encodings (MODE_ONEHOT, MODE_THERM, MODE_SCAN) and the state enum (IDLE, SCAN).
REQ-033 A combinational sub-module decode_core (inputs: code, thermometer select; output: N-bit pattern) SHALL be instantiated once; the FSM, counter and output register live in scan_decoder.

Verification
REQ-034 Scenario: W=3, one-hot, codes 0..7, out_ready=1 -> result 00000001..10000000 one cycle after each accept, out_last=1 each beat.
REQ-035 Scenario: thermometer, codes 0, 3, 7 -> 00000001, 00001111, 11111111.
REQ-036 Scenario: scan from code 6, out_ready=1 -> 8 consecutive beats 01000000, 10000000, 00000001, ..., 00100000, out_last only on the 8th, in_ready=0 throughout.
REQ-037 Scenario: out_ready=0 for 3 cycles mid-scan -> result and out_valid stable, no code skipped afterwards.
REQ-038 Scenario: reset asserted at scan beat 4 -> outputs zero immediately; a new one-hot request for code 2 after release -> 00000100.
REQ-039 Scenario: en=0 for 2 cycles mid-scan with out_ready=1 -> beat gap, sequence resumes at the next code, total of 8 beats.
